// File: rtl/fsic_axis_pkg.sv
// ---------------------------------------------------------------------------
// fsic_axis_pkg
//   Shared types and width helpers for the AXI-Stream packet FIFO.
//   - pkt_fifo_state_e : packet-mode state (store-and-forward / cut-through)
//   - strb_width()     : byte-lane count for a given tdata width
//   - entry_width()    : stored word width {tdata, tstrb, tkeep, tuser, tlast}
// ---------------------------------------------------------------------------
package fsic_axis_pkg;

    typedef enum logic {
        ST_STORE = 1'b0,
        ST_CUT   = 1'b1
    } pkt_fifo_state_e;

    localparam int BYTE_W = 8;

    function automatic int strb_width(input int data_w);
        return data_w / BYTE_W;
    endfunction

    function automatic int entry_width(input int data_w, input int user_w);
        return data_w + 2 * strb_width(data_w) + user_w + 1;
    endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// ---------------------------------------------------------------------------
// axis_fifo_mem
//   DEPTH x WIDTH storage array for the packet FIFO. One synchronous write
//   port and one asynchronous read port, so the FIFO head is visible in the
//   same cycle its read pointer selects it. Contents are never reset.
//
//   clk        in   clock
//   wr_en_i    in   write strobe
//   wr_addr_i  in   write address
//   wr_data_i  in   write word
//   rd_addr_i  in   read address
//   rd_data_o  out  read word (combinational)
// ---------------------------------------------------------------------------
module axis_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 45,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/axis_pkt_fifo.sv
// ---------------------------------------------------------------------------
// axis_pkt_fifo
//   AXI-Stream FIFO carrying tdata/tstrb/tkeep/tuser/tlast.
//   PKT_MODE=0 : first-word-fall-through streaming.
//   PKT_MODE=1 : store-and-forward; the head is released only once a
//                complete packet (tlast) is stored. A packet that fills the
//                whole FIFO without tlast switches to cut-through until its
//                tlast beat leaves, and raises sticky oversize_err.
//
//   clk, rst_n           clock, asynchronous active-low reset
//   clear                synchronous flush (overrides all same-cycle events)
//   s_t*                 write-side AXI-Stream slave
//   m_t*                 read-side AXI-Stream master (all zero when !m_tvalid)
//   level                stored beat count
//   pkt_count            complete packets stored
//   almost_full          level >= AFULL_THR
//   empty                level == 0
//   oversize_err         sticky, packet exceeded DEPTH in packet mode
// ---------------------------------------------------------------------------
module axis_pkt_fifo
    import fsic_axis_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int USER_W    = 2,
    parameter int DEPTH     = 16,
    parameter int PKT_MODE  = 0,
    parameter int AFULL_THR = DEPTH - 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic [DATA_W-1:0]       s_tdata,
    input  logic [DATA_W/8-1:0]     s_tstrb,
    input  logic [DATA_W/8-1:0]     s_tkeep,
    input  logic [USER_W-1:0]       s_tuser,
    input  logic                    s_tlast,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [DATA_W-1:0]       m_tdata,
    output logic [DATA_W/8-1:0]     m_tstrb,
    output logic [DATA_W/8-1:0]     m_tkeep,
    output logic [USER_W-1:0]       m_tuser,
    output logic                    m_tlast,
    output logic [$clog2(DEPTH):0]  level,
    output logic [$clog2(DEPTH):0]  pkt_count,
    output logic                    almost_full,
    output logic                    empty,
    output logic                    oversize_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = strb_width(DATA_W);
    localparam int EW = entry_width(DATA_W, USER_W);

    localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] FULL_LVL  = (AW + 1)'(DEPTH);
    localparam logic [AW:0] AFULL_LVL = (AW + 1)'(AFULL_THR);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      pkt_count_q, pkt_count_d;
    pkt_fifo_state_e  state_q, state_d;
    logic             oversize_q, oversize_d;

    logic [AW:0]      level_w;
    logic             full_w;
    logic             wr_en;
    logic             rd_en;
    logic             head_valid;
    logic [EW-1:0]    wr_word;
    logic [EW-1:0]    rd_word;
    logic             rd_last;

    assign level_w = wr_ptr_q - rd_ptr_q;
    assign full_w  = (level_w == FULL_LVL);

    assign s_tready = !full_w && !clear;
    assign wr_en    = s_tvalid && s_tready;
    assign wr_word  = {s_tdata, s_tstrb, s_tkeep, s_tuser, s_tlast};

    axis_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW),
        .AW    (AW)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i (wr_word),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_data_o (rd_word)
    );

    assign rd_last = rd_word[0];

    // In store-and-forward the head is only offered once a whole packet is
    // inside; cut-through (and stream mode) offers whatever is stored.
    always_comb begin
        head_valid = (level_w != '0);
        if (PKT_MODE != 0 && state_q == ST_STORE) begin
            head_valid = (pkt_count_q != '0);
        end
    end

    assign m_tvalid = head_valid && !clear;
    assign rd_en    = m_tvalid && m_tready;

    // Gate the read mux so unwritten (X) memory never reaches the outputs.
    assign {m_tdata, m_tstrb, m_tkeep, m_tuser, m_tlast} = m_tvalid ? rd_word : '0;

    assign level        = level_w;
    assign pkt_count    = pkt_count_q;
    assign almost_full  = (level_w >= AFULL_LVL);
    assign empty        = (level_w == '0);
    assign oversize_err = oversize_q;

    always_comb begin
        wr_ptr_d    = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d    = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        pkt_count_d = pkt_count_q;
        state_d     = state_q;
        oversize_d  = oversize_q;

        case ({wr_en && s_tlast, rd_en && rd_last})
            2'b10:   pkt_count_d = pkt_count_q + PTR_ONE;
            2'b01:   pkt_count_d = pkt_count_q - PTR_ONE;
            default: pkt_count_d = pkt_count_q;
        endcase

        if (PKT_MODE != 0) begin
            case (state_q)
                ST_STORE: begin
                    // Full with no complete packet: nothing could ever drain,
                    // so fall back to cut-through for this packet.
                    if (full_w && pkt_count_q == '0) begin
                        state_d    = ST_CUT;
                        oversize_d = 1'b1;
                    end
                end
                ST_CUT: begin
                    if (rd_en && rd_last) begin
                        state_d = ST_STORE;
                    end
                end
                default: state_d = ST_STORE;
            endcase
        end

        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            pkt_count_d = '0;
            state_d     = ST_STORE;
            oversize_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pkt_count_q <= '0;
            state_q     <= ST_STORE;
            oversize_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pkt_count_q <= pkt_count_d;
            state_q     <= state_d;
            oversize_q  <= oversize_d;
        end
    end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// ---------------------------------------------------------------------------
// tb_axis_pkt_fifo
//   Two DEPTH=4 instances share one set of inputs: u_str (PKT_MODE=0) and
//   u_pkt (PKT_MODE=1). Each is checked every cycle against a queue-level
//   reference model; directed table rows add hand-derived expectations for
//   one chosen instance.
// ---------------------------------------------------------------------------
module tb_axis_pkt_fifo;

    localparam int DEPTH = 4;
    localparam int AFULL = DEPTH - 2;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic [3:0]  keep;
        logic [1:0]  user;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic        rdy;
        logic        val;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [3:0]  keep;
        logic [1:0]  user;
        logic        last;
        logic [2:0]  lvl;
        logic [2:0]  pkt;
        logic        af;
        logic        emp;
        logic        ovf;
    } obs_t;

    typedef struct packed {
        logic        rdy;
        logic        val;
        logic [31:0] data;
        logic        last;
        logic [2:0]  lvl;
        logic [2:0]  pkt;
        logic        af;
        logic        ovf;
    } tobs_t;

    typedef struct {
        logic       sv;
        logic [7:0] code;
        logic       last;
        logic       mr;
        logic       clr;
        int         inst;
        tobs_t      exp;
    } vec_t;

    logic clk, rst_n, clear;
    logic s_tvalid, s_tlast, m_tready;
    logic [31:0] s_tdata;
    logic [3:0]  s_tstrb, s_tkeep;
    logic [1:0]  s_tuser;

    logic        o0_s_tready, o0_m_tvalid, o0_m_tlast, o0_af, o0_empty, o0_ovf;
    logic [31:0] o0_m_tdata;
    logic [3:0]  o0_m_tstrb, o0_m_tkeep;
    logic [1:0]  o0_m_tuser;
    logic [2:0]  o0_level, o0_pkt;

    logic        o1_s_tready, o1_m_tvalid, o1_m_tlast, o1_af, o1_empty, o1_ovf;
    logic [31:0] o1_m_tdata;
    logic [3:0]  o1_m_tstrb, o1_m_tkeep;
    logic [1:0]  o1_m_tuser;
    logic [2:0]  o1_level, o1_pkt;

    int total = 0;
    int bad   = 0;

    // Reference model: beats held in arrival order, index 0 is the head.
    beat_t mbuf [2][DEPTH];
    int    mcnt [2];
    logic  mcut [2];
    logic  movf [2];

    vec_t tbl [49];

    axis_pkt_fifo #(.DATA_W(32), .USER_W(2), .DEPTH(DEPTH), .PKT_MODE(0)) u_str (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .s_tvalid(s_tvalid), .s_tready(o0_s_tready), .s_tdata(s_tdata),
        .s_tstrb(s_tstrb), .s_tkeep(s_tkeep), .s_tuser(s_tuser), .s_tlast(s_tlast),
        .m_tvalid(o0_m_tvalid), .m_tready(m_tready), .m_tdata(o0_m_tdata),
        .m_tstrb(o0_m_tstrb), .m_tkeep(o0_m_tkeep), .m_tuser(o0_m_tuser), .m_tlast(o0_m_tlast),
        .level(o0_level), .pkt_count(o0_pkt), .almost_full(o0_af),
        .empty(o0_empty), .oversize_err(o0_ovf)
    );

    axis_pkt_fifo #(.DATA_W(32), .USER_W(2), .DEPTH(DEPTH), .PKT_MODE(1)) u_pkt (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .s_tvalid(s_tvalid), .s_tready(o1_s_tready), .s_tdata(s_tdata),
        .s_tstrb(s_tstrb), .s_tkeep(s_tkeep), .s_tuser(s_tuser), .s_tlast(s_tlast),
        .m_tvalid(o1_m_tvalid), .m_tready(m_tready), .m_tdata(o1_m_tdata),
        .m_tstrb(o1_m_tstrb), .m_tkeep(o1_m_tkeep), .m_tuser(o1_m_tuser), .m_tlast(o1_m_tlast),
        .level(o1_level), .pkt_count(o1_pkt), .almost_full(o1_af),
        .empty(o1_empty), .oversize_err(o1_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mkdata(input logic [7:0] code);
        return {code, ~code, code ^ 8'h5a, code};
    endfunction

    function automatic obs_t get_obs(input int i);
        obs_t o;
        if (i == 0)
            o = {o0_s_tready, o0_m_tvalid, o0_m_tdata, o0_m_tstrb, o0_m_tkeep, o0_m_tuser,
                 o0_m_tlast, o0_level, o0_pkt, o0_af, o0_empty, o0_ovf};
        else
            o = {o1_s_tready, o1_m_tvalid, o1_m_tdata, o1_m_tstrb, o1_m_tkeep, o1_m_tuser,
                 o1_m_tlast, o1_level, o1_pkt, o1_af, o1_empty, o1_ovf};
        return o;
    endfunction

    function automatic obs_t model_obs(input int i);
        obs_t  o;
        int    lasts;
        logic  valid;
        beat_t b;
        lasts = 0;
        for (int k = 0; k < mcnt[i]; k++) if (mbuf[i][k].last) lasts++;
        o = '0;
        o.rdy = (mcnt[i] != DEPTH) && !clear;
        if (i == 0)       valid = (mcnt[i] > 0);
        else if (mcut[i]) valid = (mcnt[i] > 0);
        else              valid = (lasts > 0);
        valid = valid && !clear;
        o.val = valid;
        if (valid) begin
            b = mbuf[i][0];
            o.data = b.data; o.strb = b.strb; o.keep = b.keep;
            o.user = b.user; o.last = b.last;
        end
        o.lvl = 3'(mcnt[i]);
        o.pkt = 3'(lasts);
        o.af  = (mcnt[i] >= AFULL);
        o.emp = (mcnt[i] == 0);
        o.ovf = movf[i];
        return o;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mcnt[i] = 0; mcut[i] = 1'b0; movf[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input int i);
        obs_t e;
        logic rd, wr;
        int   lasts;
        if (clear) begin
            mcnt[i] = 0; mcut[i] = 1'b0; movf[i] = 1'b0;
        end else begin
            e  = model_obs(i);
            rd = e.val && m_tready;
            wr = s_tvalid && e.rdy;
            lasts = int'(e.pkt);
            if (i == 1) begin
                if (!mcut[i] && mcnt[i] == DEPTH && lasts == 0) begin
                    mcut[i] = 1'b1; movf[i] = 1'b1;
                end else if (mcut[i] && rd && mbuf[i][0].last) begin
                    mcut[i] = 1'b0;
                end
            end
            if (rd) begin
                for (int k = 0; k < mcnt[i] - 1; k++) mbuf[i][k] = mbuf[i][k + 1];
                mcnt[i]--;
            end
            if (wr) begin
                mbuf[i][mcnt[i]] = {s_tdata, s_tstrb, s_tkeep, s_tuser, s_tlast};
                mcnt[i]++;
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_models(input string tag);
        chk($sformatf("%s model str", tag), 64'(get_obs(0)), 64'(model_obs(0)));
        chk($sformatf("%s model pkt", tag), 64'(get_obs(1)), 64'(model_obs(1)));
    endtask

    task automatic drive(input logic sv, input logic [7:0] code, input logic last,
                         input logic mr, input logic clr);
        s_tvalid = sv;
        s_tdata  = mkdata(code);
        s_tstrb  = code[3:0];
        s_tkeep  = code[7:4];
        s_tuser  = code[1:0];
        s_tlast  = last;
        m_tready = mr;
        clear    = clr;
    endtask

    // Commit the model to the upcoming edge, then move to the next drive point.
    task automatic advance();
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input logic sv, input logic [7:0] code, input logic last,
                        input logic mr, input logic clr, input string tag);
        drive(sv, code, last, mr, clr);
        #1;
        check_models(tag);
        advance();
    endtask

    function automatic vec_t R(input int sv, input int code, input int last, input int mr,
                               input int clr, input int inst, input int rdy, input int val,
                               input int ecode, input int elast, input int lvl, input int pkt,
                               input int af, input int ovf);
        vec_t v;
        v.sv = sv[0]; v.code = code[7:0]; v.last = last[0]; v.mr = mr[0];
        v.clr = clr[0]; v.inst = inst;
        v.exp.rdy  = rdy[0];
        v.exp.val  = val[0];
        v.exp.data = val[0] ? mkdata(ecode[7:0]) : 32'h0;
        v.exp.last = elast[0];
        v.exp.lvl  = lvl[2:0];
        v.exp.pkt  = pkt[2:0];
        v.exp.af   = af[0];
        v.exp.ovf  = ovf[0];
        return v;
    endfunction

    initial begin
        obs_t  o;
        tobs_t t;

        // Stream instance: fill to full, blocked writes, drain in order.
        //            sv code  l mr c  i rdy v  ecode el lv pk af ov
        tbl[0]  = R(1, 'hA1, 0, 0, 0, 0, 1, 0, 'h00, 0, 0, 0, 0, 0);
        tbl[1]  = R(1, 'hA2, 0, 0, 0, 0, 1, 1, 'hA1, 0, 1, 0, 0, 0);
        tbl[2]  = R(1, 'hA3, 0, 0, 0, 0, 1, 1, 'hA1, 0, 2, 0, 1, 0);
        tbl[3]  = R(1, 'hA4, 0, 0, 0, 0, 1, 1, 'hA1, 0, 3, 0, 1, 0);
        tbl[4]  = R(1, 'hA5, 0, 0, 0, 0, 0, 1, 'hA1, 0, 4, 0, 1, 0);
        tbl[5]  = R(1, 'hA5, 0, 1, 0, 0, 0, 1, 'hA1, 0, 4, 0, 1, 0);
        tbl[6]  = R(0, 'h00, 0, 1, 0, 0, 1, 1, 'hA2, 0, 3, 0, 1, 0);
        tbl[7]  = R(0, 'h00, 0, 1, 0, 0, 1, 1, 'hA3, 0, 2, 0, 1, 0);
        tbl[8]  = R(0, 'h00, 0, 1, 0, 0, 1, 1, 'hA4, 0, 1, 0, 0, 0);
        tbl[9]  = R(0, 'h00, 0, 0, 0, 0, 1, 0, 'h00, 0, 0, 0, 0, 0);
        tbl[10] = R(0, 'h00, 0, 0, 1, 0, 0, 0, 'h00, 0, 0, 0, 0, 0);
        // Stream instance: level 2 held through 5 simultaneous read+write.
        tbl[11] = R(1, 'hB1, 0, 0, 0, 0, 1, 0, 'h00, 0, 0, 0, 0, 0);
        tbl[12] = R(1, 'hB2, 0, 0, 0, 0, 1, 1, 'hB1, 0, 1, 0, 0, 0);
        tbl[13] = R(1, 'hB3, 0, 1, 0, 0, 1, 1, 'hB1, 0, 2, 0, 1, 0);
        tbl[14] = R(1, 'hB4, 0, 1, 0, 0, 1, 1, 'hB2, 0, 2, 0, 1, 0);
        tbl[15] = R(1, 'hB5, 0, 1, 0, 0, 1, 1, 'hB3, 0, 2, 0, 1, 0);
        tbl[16] = R(1, 'hB6, 0, 1, 0, 0, 1, 1, 'hB4, 0, 2, 0, 1, 0);
        tbl[17] = R(1, 'hB7, 0, 1, 0, 0, 1, 1, 'hB5, 0, 2, 0, 1, 0);
        tbl[18] = R(0, 'h00, 0, 1, 0, 0, 1, 1, 'hB6, 0, 2, 0, 1, 0);
        tbl[19] = R(0, 'h00, 0, 1, 0, 0, 1, 1, 'hB7, 0, 1, 0, 0, 0);
        tbl[20] = R(0, 'h00, 0, 0, 0, 0, 1, 0, 'h00, 0, 0, 0, 0, 0);
        tbl[21] = R(0, 'h00, 0, 0, 1, 0, 0, 0, 'h00, 0, 0, 0, 0, 0);
        // Packet instance: 3-beat packet held until its tlast is stored.
        tbl[22] = R(1, 'hC1, 0, 1, 0, 1, 1, 0, 'h00, 0, 0, 0, 0, 0);
        tbl[23] = R(1, 'hC2, 0, 1, 0, 1, 1, 0, 'h00, 0, 1, 0, 0, 0);
        tbl[24] = R(1, 'hC3, 1, 1, 0, 1, 1, 0, 'h00, 0, 2, 0, 1, 0);
        tbl[25] = R(0, 'h00, 0, 0, 0, 1, 1, 1, 'hC1, 0, 3, 1, 1, 0);
        tbl[26] = R(0, 'h00, 0, 1, 0, 1, 1, 1, 'hC1, 0, 3, 1, 1, 0);
        tbl[27] = R(0, 'h00, 0, 1, 0, 1, 1, 1, 'hC2, 0, 2, 1, 1, 0);
        tbl[28] = R(0, 'h00, 0, 1, 0, 1, 1, 1, 'hC3, 1, 1, 1, 0, 0);
        tbl[29] = R(0, 'h00, 0, 0, 0, 1, 1, 0, 'h00, 0, 0, 0, 0, 0);
        // Packet instance: 6-beat oversize packet falls back to cut-through.
        tbl[30] = R(1, 'hD1, 0, 0, 0, 1, 1, 0, 'h00, 0, 0, 0, 0, 0);
        tbl[31] = R(1, 'hD2, 0, 0, 0, 1, 1, 0, 'h00, 0, 1, 0, 0, 0);
        tbl[32] = R(1, 'hD3, 0, 0, 0, 1, 1, 0, 'h00, 0, 2, 0, 1, 0);
        tbl[33] = R(1, 'hD4, 0, 0, 0, 1, 1, 0, 'h00, 0, 3, 0, 1, 0);
        tbl[34] = R(1, 'hD5, 0, 0, 0, 1, 0, 0, 'h00, 0, 4, 0, 1, 0);
        tbl[35] = R(1, 'hD5, 0, 0, 0, 1, 0, 1, 'hD1, 0, 4, 0, 1, 1);
        tbl[36] = R(1, 'hD5, 0, 1, 0, 1, 0, 1, 'hD1, 0, 4, 0, 1, 1);
        tbl[37] = R(1, 'hD5, 0, 1, 0, 1, 1, 1, 'hD2, 0, 3, 0, 1, 1);
        tbl[38] = R(1, 'hD6, 1, 1, 0, 1, 1, 1, 'hD3, 0, 3, 0, 1, 1);
        tbl[39] = R(0, 'h00, 0, 1, 0, 1, 1, 1, 'hD4, 0, 3, 1, 1, 1);
        tbl[40] = R(0, 'h00, 0, 1, 0, 1, 1, 1, 'hD5, 0, 2, 1, 1, 1);
        tbl[41] = R(0, 'h00, 0, 1, 0, 1, 1, 1, 'hD6, 1, 1, 1, 0, 1);
        tbl[42] = R(0, 'h00, 0, 0, 0, 1, 1, 0, 'h00, 0, 0, 0, 0, 1);
        tbl[43] = R(1, 'hE1, 0, 1, 0, 1, 1, 0, 'h00, 0, 0, 0, 0, 1);
        tbl[44] = R(0, 'h00, 0, 1, 0, 1, 1, 0, 'h00, 0, 1, 0, 0, 1);
        // Packet instance: clear at level 3 / one packet, with traffic offered.
        tbl[45] = R(1, 'hE2, 1, 0, 0, 1, 1, 0, 'h00, 0, 1, 0, 0, 1);
        tbl[46] = R(1, 'hE3, 0, 0, 0, 1, 1, 1, 'hE1, 0, 2, 1, 1, 1);
        tbl[47] = R(1, 'hE4, 0, 1, 1, 1, 0, 0, 'h00, 0, 3, 1, 1, 1);
        tbl[48] = R(0, 'h00, 0, 0, 0, 1, 1, 0, 'h00, 0, 0, 0, 0, 0);

        rst_n = 1'b0;
        drive(0, 8'h00, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("reset str", {56'h0, o0_s_tready, o0_m_tvalid, o0_empty, o0_af, o0_ovf, o0_level},
            {56'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0});
        check_models("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < 49; r++) begin
            drive(tbl[r].sv, tbl[r].code, tbl[r].last, tbl[r].mr, tbl[r].clr);
            #1;
            o = get_obs(tbl[r].inst);
            t = {o.rdy, o.val, o.data, o.last, o.lvl, o.pkt, o.af, o.ovf};
            chk($sformatf("row%0d inst%0d", r, tbl[r].inst), 64'(t), 64'(tbl[r].exp));
            check_models($sformatf("row%0d", r));
            advance();
        end

        // Asynchronous reset in the middle of a packet.
        step(1, 8'hF1, 0, 0, 0, "pre_rst0");
        step(1, 8'hF2, 0, 0, 0, "pre_rst1");
        drive(0, 8'h00, 0, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async rst str", {58'h0, o0_m_tvalid, o0_s_tready, o0_level},
            {58'h0, 1'b0, 1'b1, 3'd0});
        chk("async rst pkt", {58'h0, o1_m_tvalid, o1_s_tready, o1_level},
            {58'h0, 1'b0, 1'b1, 3'd0});
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 8'h61, 1, 0, 0, "post_rst");
        drive(0, 8'h00, 0, 0, 0);
        #1;
        chk("post rst first beat", {30'h0, o0_m_tvalid, o0_m_tdata, o1_m_tvalid},
            {30'h0, 1'b1, mkdata(8'h61), 1'b1});
        check_models("post_rst idle");
        advance();

        // Randomised traffic, alternating between drain-heavy and fill-heavy.
        for (int n = 0; n < 3000; n++) begin
            s_tvalid = ($urandom_range(0, 9) < 7);
            s_tdata  = $urandom;
            s_tstrb  = 4'($urandom);
            s_tkeep  = 4'($urandom);
            s_tuser  = 2'($urandom);
            s_tlast  = ($urandom_range(0, 3) == 0);
            m_tready = ((n / 300) % 2 == 0) ? ($urandom_range(0, 9) < 8)
                                            : ($urandom_range(0, 9) < 3);
            clear    = ($urandom_range(0, 63) == 0);
            #1;
            check_models($sformatf("rnd%0d", n));
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
